// File: rtl/nibble_adder_pkg.sv
// Shared FSM state encoding and slice width for the nibble-serial adder.
package nibble_adder_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rca4_slice.sv
// 4-bit ripple-carry adder built from full adders. Also exposes the carry
// into the top bit so the parent can form two's-complement overflow.
module rca4_slice
  import nibble_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               c_msb,
  output logic               cout
);

  logic [SLICE_W:0] c;

  // Full-adder chain, LSB to MSB.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign c_msb = c[SLICE_W-1];
  assign cout  = c[SLICE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial W-bit adder: one nibble per cycle through a single 4-bit slice,
// valid/ready handshake on both sides, one operation in flight at a time.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int NIBBLES = W / SLICE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx;
  logic [W-1:0]       a_q, b_q;
  logic               carry;
  logic [W-1:0]       sum_q;
  logic               ovf_q;
  logic               accept;
  logic               last;

  logic [SLICE_W-1:0] slice_sum;
  logic               slice_c_msb;
  logic               slice_cout;

  assign last = (idx == LAST_IDX);

  rca4_slice u_slice (
    .a     (a_q[SLICE_W*int'(idx) +: SLICE_W]),
    .b     (b_q[SLICE_W*int'(idx) +: SLICE_W]),
    .cin   (carry),
    .sum   (slice_sum),
    .c_msb (slice_c_msb),
    .cout  (slice_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and per-nibble accumulation; results hold in DONE/IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      carry <= cin;
      idx   <= '0;
    end else if (state == RUN) begin
      sum_q[SLICE_W*int'(idx) +: SLICE_W] <= slice_sum;
      carry <= slice_cout;
      idx   <= idx + 1'b1;
      if (last) ovf_q <= slice_c_msb ^ slice_cout;
    end
  end

  assign sum  = sum_q;
  assign cout = carry;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed vector table, back-pressure and
// reset corner sequences, and a randomized run against a + b + cin.
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } result_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  result_t sb_q[$];
  int passed = 0;
  int total  = 0;

  nibble_serial_adder #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic result_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    result_t     r;
    logic [W:0]  full;
    full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
    return r;
  endfunction

  // One complete transaction. hold = cycles of out_ready=0 in DONE;
  // poke drives a fresh in_valid with junk operands while busy.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_op, input logic tc,
                        input result_t exp, input int hold, input bit poke);
    int      n;
    result_t got;
    result_t e;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(n < 50), 32'd1);
    a = ta; b = tb_op; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    sb_q.push_back(exp);
    @(negedge clk);
    in_valid = poke;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      check("busy_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'($urandom);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency", 32'(n), 32'(W / 4));
    out_ready = 1'b0;
    e = sb_q[0];
    for (int i = 0; i < hold; i++) begin
      a = W'($urandom); b = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_sum", 32'(sum), 32'(e.sum));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    got.sum = sum; got.cout = cout; got.ovf = ovf;
    e = sb_q.pop_front();
    check("sum", 32'(got.sum), 32'(e.sum));
    check("cout", 32'(got.cout), 32'(e.cout));
    check("ovf", 32'(got.ovf), 32'(e.ovf));
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    result_t r;
    int      n;
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    foreach (vecs[i]) begin
      r.sum = vecs[i].sum; r.cout = vecs[i].cout; r.ovf = vecs[i].ovf;
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, r, 0, 1'b0);
    end

    // Back-pressure in DONE with in_valid poked; next op must still work
    r.sum = 16'h3579; r.cout = 1'b0; r.ovf = 1'b0;
    run_op(16'h1111, 16'h2468, 1'b0, r, 5, 1'b1);
    r.sum = 16'hA000; r.cout = 1'b0; r.ovf = 1'b1;
    run_op(16'h5000, 16'h5000, 1'b0, r, 0, 1'b0);

    // Reset in the 2nd RUN cycle aborts the operation
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("stale_valid", 32'(n), 32'd0);
    r.sum = 16'h0002; r.cout = 1'b0; r.ovf = 1'b0;
    run_op(16'h0001, 16'h0001, 1'b0, r, 0, 1'b0);

    // Randomized operands with random back-pressure
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      r  = model(ra, rb, rc);
      run_op(ra, rb, rc, r, int'($urandom_range(0, 3)), 1'($urandom));
    end

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
